pipe_mux_n: RTL
===============

Name: pipe_mux_n

Overview:
- Parametrised, pipelined N:1 word selector. Successor to the combinational 4:1 operand mux.
- Builds a binary tree of 2:1 select levels, with optional pipeline registers between levels and a mandatory output register.
- Carries a valid bit with each stage and supports pipeline stall and flush.
- Used on datapath operand/forwarding select where the flat mux tree is timing-critical at wide fan-in.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of input words; must be a power of two, >= 2.
- PIPE_EVERY, 0, insert a register after every PIPE_EVERY tree levels; 0 = output register only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; word i = in_data[i*WIDTH +: WIDTH].
- sel  input  clog2(NUM_IN)  index of the word to forward.
- in_valid  input  1  qualifies in_data/sel this cycle.
- stall  input  1  freezes every stage (data and valid held).
- flush  input  1  invalidates every stage.
- out_data  output  WIDTH  selected word, registered.
- out_valid  output  1  out_data holds a valid result.

Behaviour:
- Tree structure:
  - L = clog2(NUM_IN) levels.
  - Level j (1..L) selects between pairs using sel bit j-1 (LSB first). sel=0 selects word 0.
  - The sel bits still needed by later levels travel with the data through every pipeline register.
- Register placement:
  - Pipeline registers sit after each level j where j is a multiple of PIPE_EVERY and j < L.
  - The output register after level L always exists.
- Latency:
  - LAT = 1 + floor((L-1)/PIPE_EVERY) cycles from in_valid to out_valid; LAT = 1 when PIPE_EVERY = 0.
  - Throughput is one word per cycle.
- Per-stage register contents: valid bit, data for each surviving tree node, and the remaining sel bits.
- Stage update priority, evaluated each rising edge:
  1. rst: all valid bits 0, all data and sel registers 0. Hence out_data = 0 and out_valid = 0 in the cycle after rst.
  2. flush, when rst = 0: all valid bits 0; data registers hold. flush overrides stall. Inputs presented in the flush cycle are dropped.
  3. stall, when rst = 0 and flush = 0: every register holds; in_valid in that cycle is ignored and lost. The producer is responsible for holding or re-presenting.
  4. Otherwise (advance): each stage valid <= upstream valid (in_valid for the first stage). Data and sel load only when the upstream valid is 1; when it is 0, data holds and only the valid bit clears.
- Outputs:
  - out_data changes only on a cycle where a valid word enters the output register.
  - out_data keeps its last valid value while out_valid = 0.
- Reset mid-stream: in-flight words are discarded; no partial result appears.
- Out-of-range sel is impossible, because NUM_IN is a power of two. An elaboration-time check must fail if NUM_IN is not a power of two or is < 2.
- No combinational path from any input to any output.

Test Plan:
- Defaults (N=4, W=32, PIPE_EVERY=0):
  - in_data = {D,C,B,A} = {0x4444_4444, 0x3333_3333, 0x2222_2222, 0x1111_1111}, sel = 2, in_valid = 1 at cycle t.
  - Required: out_data = 0x3333_3333 and out_valid = 1 at t+1.
- PIPE_EVERY=1 (LAT=2):
  - sel = 0, 1, 2, 3 on consecutive cycles, each with in_valid = 1.
  - Required: out_data = A, B, C, D on cycles t+2..t+5, out_valid continuously 1.
- Stall, PIPE_EVERY=1:
  - Stream sel = 1, then 3; assert stall for 2 cycles while sel=1 is in the middle stage.
  - Required: out_valid/out_data frozen for 2 cycles, then B followed by D with no loss or duplication.
- Flush with stall, PIPE_EVERY=1:
  - Two valid words in flight; assert flush and stall together.
  - Required: out_valid = 0 for the next 2 cycles and out_data holds its previous value.
- Reset:
  - rst = 1 for one cycle while a word is in flight.
  - Required: out_data = 0x0000_0000 and out_valid = 0 after the edge; the next valid input appears exactly LAT cycles after presentation.
- Wide configuration (N=16, W=8, PIPE_EVERY=2, LAT=2):
  - in_data[i] = i + 0x10; sweep sel = 0..15.
  - Required: out_data = 0x10..0x1F in order, each at +2 cycles.

Source files
------------

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: parametrised, pipelined N:1 word selector.
//
// A binary tree of 2:1 select levels picks one of NUM_IN packed words. Level j
// (1..L, L = clog2(NUM_IN)) steers on sel bit j-1, LSB first. A register can be
// placed after every PIPE_EVERY levels, and the output register always exists.
// Each register stage carries a valid bit, the surviving tree nodes and the sel
// bits that later levels still need. Stages honour rst > flush > stall > advance.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    NUM_IN packed words, word i = in_data[i*WIDTH +: WIDTH]
//   sel        index of the word to forward
//   in_valid   qualifies in_data/sel this cycle
//   stall      freezes every stage
//   flush      invalidates every stage, data held
//   out_data   selected word, registered
//   out_valid  out_data holds a valid result
module pipe_mux_n #(
  parameter int WIDTH      = 32,
  parameter int NUM_IN     = 4,
  parameter int PIPE_EVERY = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*WIDTH-1:0]     in_data,
  input  logic [$clog2(NUM_IN)-1:0]   sel,
  input  logic                        in_valid,
  input  logic                        stall,
  input  logic                        flush,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid
);

  localparam int LEVELS = $clog2(NUM_IN);
  // Divisor that is never zero, so the placement test below stays legal when
  // PIPE_EVERY = 0 (no intermediate registers at all).
  localparam int PE_DIV = (PIPE_EVERY > 0) ? PIPE_EVERY : 1;

  if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
    $error("pipe_mux_n: NUM_IN must be a power of two and at least 2");
  end

  // Levels 1..L-1. Each level halves the word count and consumes the lowest
  // remaining sel bit; the rest of sel is forwarded alongside the data.
  for (genvar j = 1; j < LEVELS; j++) begin : g_lvl
    localparam int NW = NUM_IN >> j;
    localparam int SW = LEVELS - j;
    localparam bit REG = (PIPE_EVERY > 0) && ((j % PE_DIV) == 0);

    logic [2*NW*WIDTH-1:0] prev_data;
    logic [SW:0]           prev_sel;
    logic                  prev_valid;
    logic [NW*WIDTH-1:0]   mux_data;
    logic [NW*WIDTH-1:0]   data_q;
    logic [SW-1:0]         sel_q;
    logic                  valid_q;

    if (j == 1) begin : g_src
      assign prev_data  = in_data;
      assign prev_sel   = sel;
      assign prev_valid = in_valid;
    end else begin : g_src
      assign prev_data  = g_lvl[j-1].data_q;
      assign prev_sel   = g_lvl[j-1].sel_q;
      assign prev_valid = g_lvl[j-1].valid_q;
    end

    // Pair up adjacent words; bit 0 of the remaining sel picks the odd one.
    always_comb begin
      mux_data = '0;
      for (int k = 0; k < NW; k++) begin
        mux_data[k*WIDTH +: WIDTH] = prev_sel[0] ? prev_data[(2*k+1)*WIDTH +: WIDTH]
                                                 : prev_data[(2*k)*WIDTH +: WIDTH];
      end
    end

    if (REG) begin : g_reg
      // Data and sel only load behind a valid word, so a bubble leaves the
      // previous contents in place and merely clears the valid bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          sel_q   <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (!stall) begin
          valid_q <= prev_valid;
          if (prev_valid) begin
            data_q <= mux_data;
            sel_q  <= prev_sel[SW:1];
          end
        end
      end
    end else begin : g_wire
      assign data_q  = mux_data;
      assign sel_q   = prev_sel[SW:1];
      assign valid_q = prev_valid;
    end
  end

  // Final level feeding the mandatory output register.
  logic [2*WIDTH-1:0] last_data;
  logic               last_sel;
  logic               last_valid;
  logic [WIDTH-1:0]   last_mux;

  if (LEVELS == 1) begin : g_last_src
    assign last_data  = in_data;
    assign last_sel   = sel[0];
    assign last_valid = in_valid;
  end else begin : g_last_src
    assign last_data  = g_lvl[LEVELS-1].data_q;
    assign last_sel   = g_lvl[LEVELS-1].sel_q[0];
    assign last_valid = g_lvl[LEVELS-1].valid_q;
  end

  assign last_mux = last_sel ? last_data[2*WIDTH-1:WIDTH] : last_data[WIDTH-1:0];

  // out_data only changes when a valid word arrives, so it keeps the last
  // result visible while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= last_valid;
      if (last_valid) begin
        out_data <= last_mux;
      end
    end
  end

endmodule
